time_set_counter: RTL and testbench

BCD 24-hour time-of-day counter with a pushbutton set mode, sitting directly upstream of the hour/minute/second display selector. It advances hh:mm:ss on a one-cycle 1 Hz enable from the frequency divider, and lets the user stop the clock and step hours, minutes or seconds with two debounced buttons. It drives the six BCD digits, a blink mask for the field being edited, and the current mode.

---
 rtl/time_set_counter_if.sv | 26 ++
 rtl/time_set_counter.sv | 184 ++++++++++++++++++
 tb/tb_time_set_counter.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_counter_if.sv
// Signal bundle between the time-of-day counter and its surroundings:
// tick/button inputs toward the counter, BCD digits, blink mask and mode back out.
interface time_set_counter_if;
    logic       tick;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] sec0;
    logic [3:0] sec1;
    logic [3:0] sec2;
    logic [3:0] sec3;
    logic [3:0] sec4;
    logic [3:0] sec5;
    logic [5:0] blank;
    logic [1:0] mode;
    logic       day_pulse;

    modport master (
        output tick, btn_mode, btn_inc,
        input  sec0, sec1, sec2, sec3, sec4, sec5, blank, mode, day_pulse
    );

    modport slave (
        input  tick, btn_mode, btn_inc,
        output sec0, sec1, sec2, sec3, sec4, sec5, blank, mode, day_pulse
    );
endinterface

// File: rtl/time_set_counter.sv
// BCD 24-hour hh:mm:ss counter advanced by a 1 Hz tick, with debounced
// mode/increment buttons for stopping the clock and editing one field.
module time_set_counter #(
    parameter int DEB_CYCLES = 3
) (
    input logic               clk,
    input logic               rst_n,
    time_set_counter_if.slave bus
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2,
        MODE_SET_SEC = 2'd3
    } mode_t;

    function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)            r = 8'h00;
        else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
        else                       r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    function automatic mode_t next_mode(input mode_t m);
        mode_t r;
        case (m)
            MODE_RUN:     r = MODE_SET_HR;
            MODE_SET_HR:  r = MODE_SET_MIN;
            MODE_SET_MIN: r = MODE_SET_SEC;
            default:      r = MODE_RUN;
        endcase
        return r;
    endfunction

    function automatic logic [5:0] blank_mask(input mode_t m, input logic ph);
        logic [5:0] r;
        case (m)
            MODE_SET_HR:  r = {ph, ph, 4'b0000};
            MODE_SET_MIN: r = {2'b00, ph, ph, 2'b00};
            MODE_SET_SEC: r = {4'b0000, ph, ph};
            default:      r = 6'b000000;
        endcase
        return r;
    endfunction

    logic [1:0]    raw_s;
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    level_r;
    logic [1:0]    level_q_r;
    logic [1:0]    press_r;
    logic [CW-1:0] deb_cnt_r [2];

    logic          mode_press_s;
    logic          inc_press_s;

    mode_t         mode_r;
    logic [7:0]    sec_r;
    logic [7:0]    min_r;
    logic [7:0]    hr_r;
    logic          phase_r;
    logic [5:0]    blank_r;
    logic          day_pulse_r;

    assign raw_s        = {bus.btn_inc, bus.btn_mode};
    assign mode_press_s = press_r[0];
    assign inc_press_s  = press_r[1];

    // Synchronize and debounce both buttons; press_r pulses one cycle after a debounced rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r      <= 2'b00;
            sync2_r      <= 2'b00;
            level_r      <= 2'b00;
            level_q_r    <= 2'b00;
            press_r      <= 2'b00;
            deb_cnt_r[0] <= {CW{1'b0}};
            deb_cnt_r[1] <= {CW{1'b0}};
        end else begin
            sync1_r   <= raw_s;
            sync2_r   <= sync1_r;
            level_q_r <= level_r;
            press_r   <= level_r & ~level_q_r;
            for (int b = 0; b < 2; b++) begin
                if (sync2_r[b] != level_r[b]) begin
                    if (deb_cnt_r[b] == DEB_LAST) begin
                        level_r[b]   <= sync2_r[b];
                        deb_cnt_r[b] <= {CW{1'b0}};
                    end else begin
                        deb_cnt_r[b] <= deb_cnt_r[b] + 1'b1;
                    end
                end else begin
                    deb_cnt_r[b] <= {CW{1'b0}};
                end
            end
        end
    end

    // Mode FSM, time-of-day registers, blink phase and the registered blank mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r      <= MODE_RUN;
            sec_r       <= 8'h00;
            min_r       <= 8'h00;
            hr_r        <= 8'h00;
            phase_r     <= 1'b0;
            blank_r     <= 6'b000000;
            day_pulse_r <= 1'b0;
        end else begin
            day_pulse_r <= 1'b0;
            case (mode_r)
                MODE_RUN: begin
                    if (bus.tick) begin
                        sec_r <= inc_bcd60(sec_r);
                        if (sec_r == 8'h59) begin
                            min_r <= inc_bcd60(min_r);
                            if (min_r == 8'h59) begin
                                hr_r        <= inc_bcd24(hr_r);
                                day_pulse_r <= (hr_r == 8'h23);
                            end
                        end
                    end
                    // Inc presses are dropped here; only mode leaves RUN.
                    if (mode_press_s) begin
                        mode_r  <= MODE_SET_HR;
                        phase_r <= 1'b0;
                        blank_r <= blank_mask(MODE_SET_HR, 1'b0);
                    end else begin
                        blank_r <= 6'b000000;
                    end
                end
                MODE_SET_HR, MODE_SET_MIN, MODE_SET_SEC: begin
                    if (mode_press_s) begin
                        mode_r  <= next_mode(mode_r);
                        phase_r <= 1'b0;
                        blank_r <= blank_mask(next_mode(mode_r), 1'b0);
                    end else if (inc_press_s) begin
                        case (mode_r)
                            MODE_SET_HR:  hr_r  <= inc_bcd24(hr_r);
                            MODE_SET_MIN: min_r <= inc_bcd60(min_r);
                            default:      sec_r <= inc_bcd60(sec_r);
                        endcase
                        phase_r <= 1'b0;
                        blank_r <= 6'b000000;
                    end else if (bus.tick) begin
                        phase_r <= ~phase_r;
                        blank_r <= blank_mask(mode_r, ~phase_r);
                    end else begin
                        phase_r <= phase_r;
                    end
                end
                default: begin
                    mode_r  <= MODE_RUN;
                    blank_r <= 6'b000000;
                end
            endcase
        end
    end

    assign bus.sec0      = sec_r[3:0];
    assign bus.sec1      = sec_r[7:4];
    assign bus.sec2      = min_r[3:0];
    assign bus.sec3      = min_r[7:4];
    assign bus.sec4      = hr_r[3:0];
    assign bus.sec5      = hr_r[7:4];
    assign bus.blank     = blank_r;
    assign bus.mode      = mode_r;
    assign bus.day_pulse = day_pulse_r;
endmodule

// File: tb/tb_time_set_counter.sv
// Directed bench for time_set_counter: a seconds-of-day model checked every
// cycle, plus hand-computed BCD expectations at the interesting points.
module tb_time_set_counter;
    localparam int D = 3;

    logic clk;
    logic rst_n;
    logic tick_s;
    logic btn_mode_s;
    logic btn_inc_s;

    int checks = 0;
    int errors = 0;

    time_set_counter_if bus ();

    assign bus.tick     = tick_s;
    assign bus.btn_mode = btn_mode_s;
    assign bus.btn_inc  = btn_inc_s;

    time_set_counter #(.DEB_CYCLES(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [23:0] digits_s = {bus.sec5, bus.sec4, bus.sec3, bus.sec2, bus.sec1, bus.sec0};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Model state: time as seconds of day, mode number, blink phase.
    int  t_m      = 0;
    int  mode_m   = 0;
    bit  phase_m  = 1'b0;
    bit  dp_m     = 1'b0;
    bit  valid_m  = 1'b0;
    int  e        = 0;
    int  rst_edge = 0;
    bit  raw_h [2][256];
    bit  lvl_h [2][256];

    function automatic bit sync_at(input int b, input int x);
        return (x > rst_edge) ? raw_h[b][x % 256] : 1'b0;
    endfunction

    function automatic bit lvl_at(input int b, input int x);
        return (x > rst_edge) ? lvl_h[b][x % 256] : 1'b0;
    endfunction

    // Model update on each rising edge from the inputs driven before it.
    initial begin : model
        bit prev, flip, mp, ip;
        int hh, mm, ss;
        forever begin
            @(posedge clk);
            e++;
            raw_h[0][e % 256] = btn_mode_s;
            raw_h[1][e % 256] = btn_inc_s;
            if (!rst_n) begin
                rst_edge = e;
                t_m = 0; mode_m = 0; phase_m = 1'b0; dp_m = 1'b0; valid_m = 1'b1;
                lvl_h[0][e % 256] = 1'b0;
                lvl_h[1][e % 256] = 1'b0;
            end else begin
                for (int b = 0; b < 2; b++) begin
                    prev = lvl_at(b, e - 1);
                    flip = 1'b1;
                    for (int j = 0; j < D; j++)
                        if (!((e - j > rst_edge) && (sync_at(b, e - j - 2) != prev))) flip = 1'b0;
                    lvl_h[b][e % 256] = flip ? ~prev : prev;
                end
                mp = (e - 1 > rst_edge) && lvl_at(0, e - 2) && !lvl_at(0, e - 3);
                ip = (e - 1 > rst_edge) && lvl_at(1, e - 2) && !lvl_at(1, e - 3);
                dp_m = 1'b0;
                if (mode_m == 0) begin
                    if (tick_s) begin
                        dp_m = (t_m == 86399);
                        t_m  = (t_m + 1) % 86400;
                    end
                    if (mp) begin mode_m = 1; phase_m = 1'b0; end
                end else if (mp) begin
                    mode_m = (mode_m + 1) % 4; phase_m = 1'b0;
                end else if (ip) begin
                    hh = t_m / 3600; mm = (t_m / 60) % 60; ss = t_m % 60;
                    if (mode_m == 1)      hh = (hh + 1) % 24;
                    else if (mode_m == 2) mm = (mm + 1) % 60;
                    else                  ss = (ss + 1) % 60;
                    t_m = hh * 3600 + mm * 60 + ss;
                    phase_m = 1'b0;
                end else if (tick_s) begin
                    phase_m = ~phase_m;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen.
    initial begin : compare
        int hh, mm, ss;
        logic [23:0] exp_dig;
        logic [5:0]  exp_blank;
        forever begin
            @(negedge clk);
            if (valid_m) begin
                hh = t_m / 3600; mm = (t_m / 60) % 60; ss = t_m % 60;
                exp_dig = {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
                case (mode_m)
                    1:       exp_blank = {phase_m, phase_m, 4'b0000};
                    2:       exp_blank = {2'b00, phase_m, phase_m, 2'b00};
                    3:       exp_blank = {4'b0000, phase_m, phase_m};
                    default: exp_blank = 6'b000000;
                endcase
                check("model_digits", 32'(digits_s), 32'(exp_dig));
                check("model_blank", 32'(bus.blank), 32'(exp_blank));
                check("model_mode", 32'(bus.mode), 32'(mode_m));
                check("model_day_pulse", 32'(bus.day_pulse), 32'(dp_m));
            end
        end
    end

    initial begin : watchdog
        repeat (99000) @(posedge clk);
        $display("FAIL watchdog: cycle budget expired");
        $fatal(1, "watchdog");
    end

    task automatic press(input bit do_mode, input bit do_inc);
        btn_mode_s = do_mode;
        btn_inc_s  = do_inc;
        repeat (D + 4) @(negedge clk);
        btn_mode_s = 1'b0;
        btn_inc_s  = 1'b0;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic tick_once;
        tick_s = 1'b1;
        @(negedge clk);
        tick_s = 1'b0;
    endtask

    initial begin : stim
        rst_n = 1'b0; tick_s = 1'b0; btn_mode_s = 1'b0; btn_inc_s = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_digits", 32'(digits_s), 32'h0);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_blank", 32'(bus.blank), 32'd0);
        check("rst_day_pulse", 32'(bus.day_pulse), 32'd0);
        rst_n = 1'b1;

        // Short bounce, then a long hold that must give exactly one transition.
        btn_mode_s = 1'b1;
        repeat (D - 1) @(negedge clk);
        btn_mode_s = 1'b0;
        repeat (D + 6) @(negedge clk);
        check("bounce_mode", 32'(bus.mode), 32'd0);
        btn_mode_s = 1'b1;
        repeat (D + 3) @(negedge clk);
        check("deb_before", 32'(bus.mode), 32'd0);
        @(negedge clk);
        check("deb_exact", 32'(bus.mode), 32'd1);
        repeat (100 - (D + 4)) @(negedge clk);
        check("deb_hold", 32'(bus.mode), 32'd1);
        btn_mode_s = 1'b0;
        repeat (D + 4) @(negedge clk);

        // Dial in 22:10:05 through the set modes.
        repeat (22) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (10) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (5) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("set_221005", 32'(digits_s), 32'h221005);
        check("back_run", 32'(bus.mode), 32'd0);

        press(1'b1, 1'b0);
        check("enter_hr_mode", 32'(bus.mode), 32'd1);
        check("enter_hr_blank", 32'(bus.blank), 32'd0);
        tick_once;
        check("blink_on", 32'(bus.blank), 32'b110000);
        tick_once;
        check("blink_off", 32'(bus.blank), 32'd0);
        tick_once;
        press(1'b0, 1'b1);
        check("inc1_blank", 32'(bus.blank), 32'd0);
        check("inc1_hr", 32'(digits_s), 32'h231005);
        repeat (3) tick_once;
        check("blink_on2", 32'(bus.blank), 32'b110000);
        press(1'b0, 1'b1);
        check("inc2_blank", 32'(bus.blank), 32'd0);
        check("hr_wrap", 32'(digits_s), 32'h001005);
        repeat (4) tick_once;
        check("frozen", 32'(digits_s), 32'h001005);

        // Build 12:59:30 and come back to SET_MIN.
        repeat (12) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (49) press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        repeat (25) press(1'b0, 1'b1);
        repeat (3) press(1'b1, 1'b0);
        check("at_125930", 32'(digits_s), 32'h125930);
        check("set_min_mode", 32'(bus.mode), 32'd2);
        press(1'b0, 1'b1);
        check("min_wrap", 32'(digits_s), 32'h120030);
        press(1'b1, 1'b0);
        repeat (29) press(1'b0, 1'b1);
        check("sec_59", 32'(digits_s), 32'h120059);
        press(1'b0, 1'b1);
        check("sec_wrap", 32'(digits_s), 32'h120000);
        press(1'b1, 1'b0);
        check("resume_mode", 32'(bus.mode), 32'd0);
        check("resume_blank", 32'(bus.blank), 32'd0);
        tick_once;
        check("resume_tick", 32'(digits_s), 32'h120001);

        // Reset in the middle of counting with tick active.
        tick_s = 1'b1;
        repeat (2) @(negedge clk);
        check("pre_rst", 32'(digits_s), 32'h120003);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick_s = 1'b0;
        check("mid_rst_digits", 32'(digits_s), 32'h0);
        check("mid_rst_mode", 32'(bus.mode), 32'd0);

        // Tick and mode press landing on the same edge.
        repeat (8) tick_once;
        check("at_8", 32'(digits_s), 32'h000008);
        btn_mode_s = 1'b1;
        repeat (D + 3) @(negedge clk);
        tick_s = 1'b1;
        @(negedge clk);
        tick_s = 1'b0;
        check("sim_tick_digits", 32'(digits_s), 32'h000009);
        check("sim_tick_mode", 32'(bus.mode), 32'd1);
        btn_mode_s = 1'b0;
        repeat (D + 4) @(negedge clk);

        // Mode and inc together in SET_MIN.
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);
        check("both_mode", 32'(bus.mode), 32'd3);
        check("both_digits", 32'(digits_s), 32'h000009);

        // Full day from reset, with carry-chain checkpoints.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick_s = 1'b1;
        for (int i = 1; i <= 86399; i++) begin
            @(negedge clk);
            if (i == 36000) check("carry_10h", 32'(digits_s), 32'h100000);
            if (i == 72000) begin
                check("carry_20h", 32'(digits_s), 32'h200000);
                check("carry_20h_dp", 32'(bus.day_pulse), 32'd0);
            end
        end
        tick_s = 1'b0;
        check("at_235959", 32'(digits_s), 32'h235959);
        tick_once;
        check("rollover", 32'(digits_s), 32'h000000);
        check("day_pulse_hi", 32'(bus.day_pulse), 32'd1);
        @(negedge clk);
        check("day_pulse_lo", 32'(bus.day_pulse), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
